mem_axi_rd_master: RTL
======================

# mem_axi_rd_master

AXI4 read master that turns the core MMU's simple read requests (instruction or data fetch) into AXI4 INCR read bursts and returns the beats in order. It is the initiator side of the memory bus the system bench drives with its AXI slave BFM, and sits between the MMU read port and the top-level `M_AXI` read channels. One outstanding transaction at a time. Read-only; write channels are not part of this block.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32, AXI address width.
- `C_M_AXI_DATA_WIDTH`, 32, AXI data width; only 32 is supported, so ARSIZE is fixed at 3'b010.
- `C_OFFSET`, 32'h0, base offset added to every request address before issue.
- `CLK  in  1  clock; all logic on the rising edge.`
- `RST  in  1  reset; asynchronous, active-low.`
- `REQ_RDEN  in  1  request strobe; sampled only when REQ_BUSY=0.`
- `REQ_RADDR  in  32  byte address; bits [1:0] are ignored and treated as 0.`
- `REQ_RLEN  in  8  beat count minus 1; valid range 0..255.`
- `REQ_FLUSH  in  1  abort the current request; takes effect in ADDR or DATA.`
- `REQ_BUSY  out  1  high while a transaction is in progress.`
- `REQ_RVALID  out  1  returned beat valid; one-cycle pulse per beat.`
- `REQ_RDATA  out  32  returned beat data.`
- `REQ_RLAST  out  1  final beat of the request; qualified by REQ_RVALID.`
- `REQ_ERR  out  1  beat error; qualified by REQ_RVALID.`
- `M_AXI_ARADDR  out  32`, `M_AXI_ARLEN  out  8`, `M_AXI_ARSIZE  out  3`, `M_AXI_ARBURST  out  2`, `M_AXI_ARVALID  out  1`, `M_AXI_ARREADY  in  1`.
- `M_AXI_RDATA  in  32`, `M_AXI_RRESP  in  2`, `M_AXI_RLAST  in  1`, `M_AXI_RVALID  in  1`, `M_AXI_RREADY  out  1`.

## Operation
- **States:** IDLE, ADDR, DATA, DRAIN. In IDLE, when REQ_RDEN=1, latch `addr = (REQ_RADDR & ~3) + C_OFFSET` and `len = REQ_RLEN`, then go to ADDR.
- **ADDR:** drive ARVALID=1, ARADDR=addr, ARLEN=len, ARBURST=2'b01 (INCR), ARSIZE=2.
  - AR payload is held stable until ARREADY.
  - On the AR handshake, go to DATA and load the beat counter with ARLEN.
- **DATA:** RREADY=1. Each R handshake forwards RDATA as REQ_RDATA.
  - REQ_ERR=1 when RRESP≠2'b00.
  - REQ_ERR=1 on an RLAST/counter mismatch: RLAST with counter≠0, or counter=0 without RLAST.
  - The transaction ends on M_AXI_RLAST, whatever the counter says.
  - REQ_RLAST=1 on the beat that carries M_AXI_RLAST of the final burst.
  - End of transaction goes to IDLE.
- **REQ_FLUSH:**
  - In ADDR: the AR handshake still completes, because ARVALID cannot be withdrawn; the block then goes to DRAIN.
  - In DATA: go to DRAIN.
  - In DRAIN: RREADY=1, no REQ_RVALID; return to IDLE after the RLAST handshake.
  - In IDLE: ignored.
- **Simultaneous events:**
  - REQ_RDEN together with FLUSH in IDLE starts a request normally.
  - FLUSH on the same cycle as the final RLAST beat: that beat is dropped, and the block returns to IDLE.
- **Address arithmetic:** modulo 2^32; no wrap checking beyond what Configuration defines.

## Timing
- **Reset values:** every output is 0 and the state is IDLE. ARSIZE=2 and ARBURST=1 are constants.
- **Request to AR:** a request accepted in cycle N gives REQ_BUSY=1 and ARVALID=1 from cycle N+1.
- **Beat latency:** REQ_RVALID/RDATA/RLAST/ERR are registered and appear 1 cycle after each R handshake. Back-to-back R beats give back-to-back REQ_RVALID.
- **REQ_BUSY:** equals (state≠IDLE). It falls the cycle after the final RLAST handshake, coincident with the last REQ_RVALID.
- **Next request:** the earliest next request is accepted in that same cycle.
- **Reset mid-operation:** asynchronous return to IDLE with all outputs 0. In-flight beats are not tracked; the system resets the slave together with this block.

## Configuration
- **`MEM_AXI_4K_SPLIT_EN` defined:**
  - A request with `addr[11:0] + 4*(len+1) > 4096` is issued as two bursts.
  - First burst: `addr` with `len1 = (4096-addr[11:0])/4 - 1`.
  - Second burst: `{addr[31:12]+1, 12'h000}` with `len - len1 - 1`.
  - States run ADDR→DATA→ADDR→DATA. REQ_RLAST is asserted only on the last beat of the second burst.
  - FLUSH drains the current burst only; the second burst is not issued.
- **Undefined:** every request is issued as a single burst unchanged, even when it crosses 4 KB. The requester is responsible for avoiding the crossing.

## Test plan
1. **Single beat:** REQ_RADDR=0x100, RLEN=0; slave returns 0xDEADBEEF with OKAY.
   - Expect ARADDR=0x100, ARLEN=0.
   - Expect one REQ_RVALID with RDATA=0xDEADBEEF, RLAST=1, ERR=0.
   - Expect BUSY low the same cycle.
2. **Delayed ARREADY:** 4-beat read at 0x2000, ARREADY delayed 3 cycles, R beats 1..4.
   - Expect ARVALID/ARADDR stable for 4 cycles.
   - Expect REQ_RDATA 1,2,3,4 in order, with RLAST only on 4.
3. **Slave error:** 4-beat read with RRESP=SLVERR on beat 2.
   - Expect REQ_ERR=1 only with beat 2; the transaction still completes.
4. **Flush mid-burst:** 16-beat read, FLUSH asserted after beat 5.
   - Expect no REQ_RVALID after beat 5.
   - Expect RREADY held through beat 16 and BUSY low the cycle after RLAST.
5. **4 KB split (`MEM_AXI_4K_SPLIT_EN`):** addr 0xFF8, RLEN=3.
   - Expect AR 0xFF8/ARLEN=1, then AR 0x1000/ARLEN=1.
   - Expect 4 REQ_RVALIDs with RLAST only on the 4th. Without the macro: a single AR 0xFF8/ARLEN=3.
6. **Reset mid-operation:** RST low during DATA of an 8-beat read.
   - Expect all outputs 0 immediately; after release, a new 1-beat read completes normally.

Source files
------------

// File: rtl/mem_axi_rd_master.sv
// mem_axi_rd_master
//   AXI4 read master with one outstanding transaction. It turns simple MMU read
//   requests into AXI4 INCR bursts (ARSIZE = 4 bytes) and returns the beats in
//   order, one registered cycle after each R handshake.
//
//   Optional feature macro: MEM_AXI_4K_SPLIT_EN
//     defined   - a request that crosses a 4 KB boundary is issued as two bursts
//     undefined - every request is issued as one burst unchanged
//
//   Ports
//     CLK, RST           clock (rising edge), asynchronous active-low reset
//     REQ_RDEN/RADDR/RLEN request strobe, byte address, beat count minus 1
//     REQ_FLUSH          abort the current request (drains the open burst)
//     REQ_BUSY           high while state != IDLE
//     REQ_RVALID/RDATA/RLAST/ERR  returned beat, registered
//     M_AXI_AR*          AXI read address channel
//     M_AXI_R*           AXI read data channel
module mem_axi_rd_master #(
   parameter int                            C_M_AXI_ADDR_WIDTH = 32,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_OFFSET           = '0
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          REQ_RDEN,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] REQ_RADDR,
   input  logic [7:0]                    REQ_RLEN,
   input  logic                          REQ_FLUSH,
   output logic                          REQ_BUSY,
   output logic                          REQ_RVALID,
   output logic [C_M_AXI_DATA_WIDTH-1:0] REQ_RDATA,
   output logic                          REQ_RLAST,
   output logic                          REQ_ERR,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [1:0]                    M_AXI_ARBURST,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RLAST,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);
   localparam int AW = C_M_AXI_ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] req_addr;    // word-aligned request address plus offset
   logic [7:0]    first_len;   // ARLEN of the first (or only) burst
   logic [7:0]    cnt;         // beats remaining minus 1 in the open burst
   logic          flush_pend;  // flush seen while AR was still pending
   logic          second;      // a second burst follows the open one

   assign req_addr      = (REQ_RADDR & ~AW'(3)) + C_OFFSET;
   assign M_AXI_ARSIZE  = 3'b010;
   assign M_AXI_ARBURST = 2'b01;

`ifdef MEM_AXI_4K_SPLIT_EN
   logic [12:0]   end_off;   // page offset one past the last byte
   logic          split_req;
   logic [7:0]    len1;
   logic [AW-1:0] nxt_addr;
   logic [7:0]    nxt_len;

   assign end_off   = {1'b0, req_addr[11:0]} + (({5'd0, REQ_RLEN} + 13'd1) << 2);
   assign split_req = end_off > 13'd4096;
   // (4096 - off)/4 - 1 == 1023 - off[11:2]; a crossing keeps it below len.
   assign len1      = ~req_addr[9:2];
   assign first_len = split_req ? len1 : REQ_RLEN;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         second   <= 1'b0;
         nxt_addr <= '0;
         nxt_len  <= '0;
      end else if (state == IDLE && REQ_RDEN) begin
         second   <= split_req;
         nxt_addr <= {req_addr[AW-1:12] + {{(AW-13){1'b0}}, 1'b1}, 12'h000};
         nxt_len  <= REQ_RLEN - len1 - 8'd1;
      end else if (state == DATA && M_AXI_RVALID && M_AXI_RLAST) begin
         second   <= 1'b0;
      end
   end
`else
   assign first_len = REQ_RLEN;
   assign second    = 1'b0;
`endif

   // state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   // next state; a transaction always ends on the slave's RLAST
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (REQ_RDEN) state_nxt = ADDR;
         ADDR:  if (M_AXI_ARREADY) state_nxt = (flush_pend || REQ_FLUSH) ? DRAIN : DATA;
         DATA: begin
            if (M_AXI_RVALID && M_AXI_RLAST) state_nxt = (second && !REQ_FLUSH) ? ADDR : IDLE;
            else if (REQ_FLUSH)              state_nxt = DRAIN;
         end
         DRAIN: if (M_AXI_RVALID && M_AXI_RLAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      M_AXI_ARVALID = (state == ADDR);
      M_AXI_RREADY  = (state == DATA) || (state == DRAIN);
      REQ_BUSY      = (state != IDLE);
   end

   // AR payload, beat counter and registered beat return
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         M_AXI_ARADDR <= '0;
         M_AXI_ARLEN  <= '0;
         cnt          <= '0;
         flush_pend   <= 1'b0;
         REQ_RVALID   <= 1'b0;
         REQ_RDATA    <= '0;
         REQ_RLAST    <= 1'b0;
         REQ_ERR      <= 1'b0;
      end else begin
         REQ_RVALID <= 1'b0;
         REQ_RLAST  <= 1'b0;
         REQ_ERR    <= 1'b0;
         case (state)
            IDLE: if (REQ_RDEN) begin
               M_AXI_ARADDR <= req_addr;
               M_AXI_ARLEN  <= first_len;
               flush_pend   <= 1'b0;
            end
            ADDR: begin
               if (REQ_FLUSH)     flush_pend <= 1'b1;
               if (M_AXI_ARREADY) cnt        <= M_AXI_ARLEN;
            end
            DATA: if (M_AXI_RVALID) begin
               cnt <= cnt - 8'd1;
               // a beat arriving with FLUSH is dropped
               if (!REQ_FLUSH) begin
                  REQ_RVALID <= 1'b1;
                  REQ_RDATA  <= M_AXI_RDATA;
                  REQ_RLAST  <= M_AXI_RLAST && !second;
                  REQ_ERR    <= (M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != (cnt == 8'd0));
               end
`ifdef MEM_AXI_4K_SPLIT_EN
               if (M_AXI_RLAST && second && !REQ_FLUSH) begin
                  M_AXI_ARADDR <= nxt_addr;
                  M_AXI_ARLEN  <= nxt_len;
               end
`endif
            end
            default: ;
         endcase
      end
   end
endmodule
